// File: rtl/pci_cfg_pkg.sv
// rtl/pci_cfg_pkg.sv - shared constants, state encoding and helpers for the PCI config target
package pci_cfg_pkg;

    localparam logic [3:0] CMD_CFG_READ  = 4'b1010;
    localparam logic [3:0] CMD_CFG_WRITE = 4'b1011;

    localparam logic [5:0] IDX_ID     = 6'd0;
    localparam logic [5:0] IDX_CMD    = 6'd1;
    localparam logic [5:0] IDX_CLASS  = 6'd2;
    localparam logic [5:0] IDX_HDR    = 6'd3;
    localparam logic [5:0] IDX_BAR0   = 6'd4;
    localparam logic [5:0] IDX_BAR1   = 6'd5;
    localparam logic [5:0] IDX_BAR2   = 6'd6;
    localparam logic [5:0] IDX_SUBSYS = 6'd11;
    localparam logic [5:0] IDX_INT    = 6'd15;

    localparam int CMD_IOEN   = 0;
    localparam int CMD_MEMEN  = 1;
    localparam int CMD_BMEN   = 2;
    localparam int CMD_INTDIS = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLAIM,
        ST_DATA,
        ST_DISC
    } cfg_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pci_cfg_bar.sv
// rtl/pci_cfg_bar.sv - one base address register with size mask and I/O flag
module pci_cfg_bar
    import pci_cfg_pkg::*;
#(
    parameter int BITS  = 12,
    parameter bit IS_IO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] bar_q,
    output logic [31:0] rd_data
);

    // Bits below the BAR size are hardwired to zero so a write of all ones reads back the size mask.
    localparam logic [31:0] MASK = 32'hFFFF_FFFF << BITS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_q <= '0;
        end else if (we) begin
            bar_q <= byte_merge(bar_q, wdata & MASK, be);
        end
    end

    assign rd_data = bar_q | {31'b0, IS_IO};

endmodule

// File: rtl/pci_cfgspace_mbar.sv
// rtl/pci_cfgspace_mbar.sv - type-0 PCI configuration-space target with up to three BARs
module pci_cfgspace_mbar
    import pci_cfg_pkg::*;
#(
    parameter int          NUM_BARS            = 2,
    parameter int          BAR0_BITS           = 12,
    parameter int          BAR1_BITS           = 16,
    parameter int          BAR2_BITS           = 8,
    parameter logic [2:0]  BAR_IO              = 3'b000,
    parameter logic [15:0] DEVICE_ID           = 16'h9501,
    parameter logic [15:0] VENDOR_ID           = 16'h106d,
    parameter logic [23:0] DEVICE_CLASS        = 24'h030000,
    parameter logic [7:0]  DEVICE_REV          = 8'h02,
    parameter logic [15:0] SUBSYSTEM_ID        = 16'h0002,
    parameter logic [15:0] SUBSYSTEM_VENDOR_ID = 16'hBEBE,
    parameter logic [7:0]  INT_PIN             = 8'h01,
    parameter logic [1:0]  DEVSEL_TIMING       = 2'b00
) (
    input  logic                  pci_clk_i,
    input  logic                  pci_rst_ni,
    input  logic                  pci_frame_ni,
    input  logic                  pci_irdy_ni,
    input  logic                  pci_idsel_i,
    input  logic [3:0]            pci_cbe_ni,
    input  logic [31:0]           pci_ad_i,
    output logic [31:0]           pci_ad_o,
    output logic                  ad_oe_o,
    output logic                  pci_devsel_no,
    output logic                  pci_trdy_no,
    output logic                  pci_stop_no,
    input  logic                  int_pending_i,
    output logic                  selected_o,
    output logic                  ioen_o,
    output logic                  memen_o,
    output logic                  bmen_o,
    output logic                  intdis_o,
    output logic [32*NUM_BARS-1:0] bar_o,
    output logic [7:0]            int_line_o
);

    cfg_state_e  state;
    logic        frame_q;
    logic [5:0]  idx;
    logic        is_read;
    logic        claim;
    logic        wr_commit;
    logic [3:0]  be;
    logic [31:0] rd_data;
    logic [31:0] bar_rd [3];

    // frame_q makes only the falling edge of FRAME# count as an address phase, so data
    // phases of transactions we did not claim can never be mistaken for one.
    assign claim = !pci_frame_ni && frame_q && pci_idsel_i &&
                   (pci_cbe_ni == CMD_CFG_READ || pci_cbe_ni == CMD_CFG_WRITE) &&
                   (pci_ad_i[1:0] == 2'b00) && (pci_ad_i[10:8] == 3'b000);

    assign wr_commit = (state == ST_DATA) && !pci_irdy_ni && !is_read;
    assign be        = ~pci_cbe_ni;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_bar
        if (g < NUM_BARS) begin : g_impl
            localparam int BITS = (g == 0) ? BAR0_BITS : (g == 1) ? BAR1_BITS : BAR2_BITS;
            pci_cfg_bar #(
                .BITS  (BITS),
                .IS_IO (BAR_IO[g])
            ) u_bar (
                .clk     (pci_clk_i),
                .rst_n   (pci_rst_ni),
                .we      (wr_commit && (idx == IDX_BAR0 + 6'(g))),
                .be      (be),
                .wdata   (pci_ad_i),
                .bar_q   (bar_o[32*g +: 32]),
                .rd_data (bar_rd[g])
            );
        end else begin : g_none
            assign bar_rd[g] = '0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            IDX_ID:     rd_data = {DEVICE_ID, VENDOR_ID};
            IDX_CMD:    rd_data = {5'b0, DEVSEL_TIMING, 5'b0, int_pending_i, 3'b0,
                                   5'b0, intdis_o, 7'b0, bmen_o, memen_o, ioen_o};
            IDX_CLASS:  rd_data = {DEVICE_CLASS, DEVICE_REV};
            IDX_HDR:    rd_data = '0;
            IDX_BAR0:   rd_data = bar_rd[0];
            IDX_BAR1:   rd_data = bar_rd[1];
            IDX_BAR2:   rd_data = bar_rd[2];
            IDX_SUBSYS: rd_data = {SUBSYSTEM_ID, SUBSYSTEM_VENDOR_ID};
            IDX_INT:    rd_data = {16'h0, INT_PIN, int_line_o};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge pci_clk_i or negedge pci_rst_ni) begin
        if (!pci_rst_ni) begin
            state         <= ST_IDLE;
            frame_q       <= 1'b1;
            idx           <= '0;
            is_read       <= 1'b0;
            pci_devsel_no <= 1'b1;
            pci_trdy_no   <= 1'b1;
            pci_stop_no   <= 1'b1;
            ad_oe_o       <= 1'b0;
            selected_o    <= 1'b0;
            pci_ad_o      <= '0;
        end else begin
            frame_q <= pci_frame_ni;
            case (state)
                ST_IDLE: begin
                    if (claim) begin
                        state         <= ST_CLAIM;
                        pci_devsel_no <= 1'b0;
                        selected_o    <= 1'b1;
                        idx           <= pci_ad_i[7:2];
                        is_read       <= (pci_cbe_ni == CMD_CFG_READ);
                        ad_oe_o       <= (pci_cbe_ni == CMD_CFG_READ);
                    end
                end
                ST_CLAIM: begin
                    // Every access is single-dword, so STOP# goes out with TRDY#.
                    state       <= ST_DATA;
                    pci_trdy_no <= 1'b0;
                    pci_stop_no <= 1'b0;
                    pci_ad_o    <= rd_data;
                end
                ST_DATA: begin
                    if (!pci_irdy_ni) begin
                        if (pci_frame_ni) begin
                            state         <= ST_IDLE;
                            pci_devsel_no <= 1'b1;
                            pci_trdy_no   <= 1'b1;
                            pci_stop_no   <= 1'b1;
                            ad_oe_o       <= 1'b0;
                            selected_o    <= 1'b0;
                            pci_ad_o      <= '0;
                        end else begin
                            state       <= ST_DISC;
                            pci_trdy_no <= 1'b1;
                        end
                    end
                end
                ST_DISC: begin
                    if (pci_frame_ni) begin
                        state         <= ST_IDLE;
                        pci_devsel_no <= 1'b1;
                        pci_trdy_no   <= 1'b1;
                        pci_stop_no   <= 1'b1;
                        ad_oe_o       <= 1'b0;
                        selected_o    <= 1'b0;
                        pci_ad_o      <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pci_clk_i or negedge pci_rst_ni) begin
        if (!pci_rst_ni) begin
            ioen_o     <= 1'b0;
            memen_o    <= 1'b0;
            bmen_o     <= 1'b0;
            intdis_o   <= 1'b0;
            int_line_o <= '0;
        end else if (wr_commit) begin
            if (idx == IDX_CMD) begin
                if (be[0]) begin
                    ioen_o  <= pci_ad_i[CMD_IOEN];
                    memen_o <= pci_ad_i[CMD_MEMEN];
                    bmen_o  <= pci_ad_i[CMD_BMEN];
                end
                if (be[1]) intdis_o <= pci_ad_i[CMD_INTDIS];
            end
            if (idx == IDX_INT && be[0]) int_line_o <= pci_ad_i[7:0];
        end
    end

endmodule
